// File: rtl/life_pkg.sv
// Shared types and default dimensions for the Game-of-Life stepper.
package life_pkg;

    localparam int unsigned LIFE_N        = 5;
    localparam int unsigned LIFE_M        = 5;
    localparam int unsigned LIFE_CELLS    = LIFE_N * LIFE_M;
    localparam int unsigned LIFE_TICK_DIV = 4;
    localparam int unsigned GEN_W         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EVO  = 2'd2,
        HOLD = 2'd3
    } life_state_t;

endpackage

// File: rtl/life_tick_counter.sv
// Loadable down-counter that saturates at zero; paces HOLD and the EVO settle wait.
module life_tick_counter #(
    parameter int unsigned P_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [P_W-1:0] load_val,
    input  logic           en,
    output logic           zero_c
);

    logic [P_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - P_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/life_stepper.sv
// Generation controller: owns the grid, loads seeds serially and commits Evolution results.
module life_stepper
    import life_pkg::*;
#(
    parameter int unsigned P_PARAM_N  = LIFE_N,
    parameter int unsigned P_PARAM_M  = LIFE_M,
    parameter int unsigned P_TICK_DIV = LIFE_TICK_DIV
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_start,
    input  logic                         load_valid,
    input  logic                         load_bit,
    output logic                         load_ready,
    input  logic                         step,
    input  logic                         run,
    output logic [P_PARAM_N*P_PARAM_M-1:0] prev,
    input  logic [P_PARAM_N*P_PARAM_M-1:0] next,
    input  logic                         finish_evo,
    output logic [GEN_W-1:0]             gen_count,
    output logic                         still_life,
    output logic                         busy
);

    localparam int unsigned CELLS  = P_PARAM_N * P_PARAM_M;
    localparam int unsigned IDX_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned TICK_W = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;

    life_state_t        state;
    logic [IDX_W-1:0]   idx;
    logic               tick_load_c;
    logic [TICK_W-1:0]  tick_val_c;
    logic               tick_en_c;
    logic               tick_zero_c;
    logic               commit_c;

    // EVO must spend one settle cycle before a result may be accepted
    assign commit_c = (state == EVO) && tick_zero_c && finish_evo;

    // Counter control: EVO entry loads 1, HOLD entry loads the pacing interval
    always_comb begin
        tick_load_c = 1'b0;
        tick_val_c  = '0;
        tick_en_c   = 1'b0;
        case (state)
            IDLE: begin
                if (!load_start && (step || run)) begin
                    tick_load_c = 1'b1;
                    tick_val_c  = TICK_W'(1);
                end
            end
            EVO: begin
                if (commit_c && run) begin
                    tick_load_c = 1'b1;
                    tick_val_c  = TICK_W'(P_TICK_DIV - 1);
                end else begin
                    tick_en_c = 1'b1;
                end
            end
            HOLD: begin
                if (!load_start && run) begin
                    if (tick_zero_c) begin
                        tick_load_c = 1'b1;
                        tick_val_c  = TICK_W'(1);
                    end else begin
                        tick_en_c = 1'b1;
                    end
                end
            end
            default: begin
                tick_load_c = 1'b0;
            end
        endcase
    end

    life_tick_counter #(
        .P_W (TICK_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tick_load_c),
        .load_val (tick_val_c),
        .en       (tick_en_c),
        .zero_c   (tick_zero_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev       <= '0;
            gen_count  <= '0;
            still_life <= 1'b0;
            load_ready <= 1'b0;
            busy       <= 1'b0;
            idx        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        prev       <= '0;
                        gen_count  <= '0;
                        still_life <= 1'b0;
                        idx        <= '0;
                        state      <= LOAD;
                        load_ready <= 1'b1;
                        busy       <= 1'b1;
                    end else if (step || run) begin
                        state <= EVO;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        prev[idx] <= load_bit;
                        if (idx == IDX_W'(CELLS - 1)) begin
                            idx        <= '0;
                            state      <= IDLE;
                            load_ready <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                EVO: begin
                    if (commit_c) begin
                        prev       <= next;
                        still_life <= (next == prev);
                        gen_count  <= gen_count + GEN_W'(1);
                        if (run) begin
                            state <= HOLD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (load_start) begin
                        prev       <= '0;
                        gen_count  <= '0;
                        still_life <= 1'b0;
                        idx        <= '0;
                        state      <= LOAD;
                        load_ready <= 1'b1;
                    end else if (!run) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tick_zero_c) begin
                        state <= EVO;
                    end
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_stepper.sv
// Directed bench for life_stepper with a behavioural Evolution stand-in.
module tb_life_stepper;

    localparam int unsigned N     = 5;
    localparam int unsigned M     = 5;
    localparam int unsigned CELLS = N * M;

    localparam logic [CELLS-1:0] PAT_HORIZ = 25'h0003800;
    localparam logic [CELLS-1:0] PAT_VERT  = 25'h0021080;
    localparam logic [CELLS-1:0] PAT_BLOCK = 25'h0000063;

    logic             clk;
    logic             rst_n;
    logic             load_start;
    logic             load_valid;
    logic             load_bit;
    logic             load_ready;
    logic             step;
    logic             run;
    logic [CELLS-1:0] prev;
    logic [CELLS-1:0] next;
    logic             finish_evo;
    logic [15:0]      gen_count;
    logic             still_life;
    logic             busy;

    int tests;
    int fails;

    life_stepper #(
        .P_PARAM_N  (N),
        .P_PARAM_M  (M),
        .P_TICK_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_bit   (load_bit),
        .load_ready (load_ready),
        .step       (step),
        .run        (run),
        .prev       (prev),
        .next       (next),
        .finish_evo (finish_evo),
        .gen_count  (gen_count),
        .still_life (still_life),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Conway rule with dead cells beyond the border
    function automatic logic [CELLS-1:0] life_next(input logic [CELLS-1:0] g);
        logic [CELLS-1:0] r;
        r = '0;
        for (int i = 0; i < int'(M); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                int nb;
                nb = 0;
                for (int di = -1; di <= 1; di++) begin
                    for (int dj = -1; dj <= 1; dj++) begin
                        if ((di != 0 || dj != 0) && (i + di >= 0) && (i + di < int'(M))
                            && (j + dj >= 0) && (j + dj < int'(N))) begin
                            nb += int'(g[(i + di) * int'(N) + (j + dj)]);
                        end
                    end
                end
                r[i * int'(N) + j] = (nb == 3) || (g[i * int'(N) + j] && nb == 2);
            end
        end
        return r;
    endfunction

    // Evolution stand-in: result registered one clock after prev
    always @(posedge clk) begin
        next <= life_next(prev);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_pattern(input logic [CELLS-1:0] pat, input int gap_every, input int restart_at);
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int k = 0; k < int'(CELLS); k++) begin
            if (gap_every > 0 && (k % gap_every) == gap_every - 1) begin
                load_valid = 1'b0;
                @(negedge clk);
            end
            load_start = (k == restart_at);
            load_valid = 1'b1;
            load_bit   = pat[k];
            @(negedge clk);
        end
        load_start = 1'b0;
        load_valid = 1'b0;
        load_bit   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic pulse_step();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    initial begin
        int busy_cycles;
        int ncommit;
        int last_t;
        int first_t;
        logic [15:0] last_gen;

        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_bit   = 1'b0;
        step       = 1'b0;
        run        = 1'b0;
        finish_evo = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_prev", 32'(prev), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_gen", 32'(gen_count), 32'd0);
        check("rst_still", 32'(still_life), 32'd0);
        rst_n = 1'b1;

        // 1: reset in the middle of a load
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b1;
        load_bit   = 1'b1;
        repeat (7) @(negedge clk);
        load_valid = 1'b0;
        check("t1_ready_in_load", 32'(load_ready), 32'd1);
        check("t1_partial_prev", 32'(prev), 32'h7f);
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_prev", 32'(prev), 32'd0);
        check("t1_rst_busy", 32'(busy), 32'd0);
        check("t1_rst_ready", 32'(load_ready), 32'd0);
        check("t1_rst_gen", 32'(gen_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: blinker with gaps, single step
        load_pattern(PAT_HORIZ, 4, -1);
        check("t2_loaded", 32'(prev), 32'(PAT_HORIZ));
        check("t2_ready_done", 32'(load_ready), 32'd0);
        check("t2_busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        step = 1'b1;
        busy_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            step = 1'b0;
            busy_cycles += int'(busy);
        end
        check("t2_busy_cycles", 32'(busy_cycles), 32'd2);
        check("t2_prev", 32'(prev), 32'(PAT_VERT));
        check("t2_gen", 32'(gen_count), 32'd1);
        check("t2_still", 32'(still_life), 32'd0);

        // 3: block is a still life
        load_pattern(PAT_BLOCK, 0, -1);
        check("t3_gen_cleared", 32'(gen_count), 32'd0);
        pulse_step();
        wait_idle("t3_idle");
        check("t3_prev", 32'(prev), 32'(PAT_BLOCK));
        check("t3_still", 32'(still_life), 32'd1);
        check("t3_gen", 32'(gen_count), 32'd1);

        // 4: free-run pacing, then stop during HOLD
        load_pattern(PAT_HORIZ, 0, -1);
        @(negedge clk);
        run      = 1'b1;
        last_gen = gen_count;
        ncommit  = 0;
        last_t   = 0;
        first_t  = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (gen_count != last_gen) begin
                ncommit++;
                check("t4_prev_alt", 32'(prev), (ncommit % 2 == 1) ? 32'(PAT_VERT) : 32'(PAT_HORIZ));
                if (ncommit == 1) first_t = c;
                else check("t4_spacing", 32'(c - last_t), 32'd6);
                last_t   = c;
                last_gen = gen_count;
            end
        end
        check("t4_first_commit", 32'(first_t), 32'd3);
        check("t4_gen", 32'(gen_count), 32'd5);
        check("t4_busy_hold", 32'(busy), 32'd1);
        run = 1'b0;
        @(negedge clk);
        check("t4_stop_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("t4_no_more", 32'(gen_count), 32'd5);
        check("t4_prev_final", 32'(prev), 32'(PAT_VERT));

        // 5: load_start inside LOAD and step inside a stalled EVO are ignored
        load_pattern(PAT_HORIZ, 0, 12);
        check("t5_loaded", 32'(prev), 32'(PAT_HORIZ));
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step       = 1'b0;
        finish_evo = 1'b0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        check("t5_stall_busy", 32'(busy), 32'd1);
        check("t5_stall_gen", 32'(gen_count), 32'd0);
        check("t5_stall_prev", 32'(prev), 32'(PAT_HORIZ));
        finish_evo = 1'b1;
        wait_idle("t5_idle");
        repeat (5) @(negedge clk);
        check("t5_gen", 32'(gen_count), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_prev", 32'(prev), 32'(PAT_VERT));

        // 6: generation counter wraps
        @(negedge clk);
        force dut.gen_count = 16'hFFFF;
        @(negedge clk);
        release dut.gen_count;
        @(negedge clk);
        check("t6_preset", 32'(gen_count), 32'hFFFF);
        pulse_step();
        wait_idle("t6_idle");
        check("t6_wrap", 32'(gen_count), 32'h0000);
        check("t6_prev", 32'(prev), 32'(PAT_HORIZ));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/life_stepper.md
Name: life_stepper

Overview:
- Generation controller and grid state owner for the Game-of-Life datapath.
- Holds the current grid, loads a seed pattern serially, and drives it as prev into the Evolution block.
- Captures Evolution's next result back into the grid, either on single-step or free-run at a programmable pace.
- Acts as the initiator/consumer on the prev/next/finish_evo interface. Display and UI logic read prev and the status outputs.

Parameters:
- P_PARAM_N, 5, grid columns; must match Evolution.
- P_PARAM_M, 5, grid rows; must match Evolution.
- P_TICK_DIV, 4, idle cycles between generations in run mode; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse: clear grid and begin serial seed load.
- load_valid  in  1  seed bit valid.
- load_bit  in  1  seed bit; row-major order, cell index i*P_PARAM_N+j, index 0 first.
- load_ready  out  1  high only in LOAD.
- step  in  1  one-cycle pulse: evolve exactly one generation.
- run  in  1  level: free-run generations while high.
- prev  out  P_PARAM_N*P_PARAM_M  current grid, registered; drives Evolution.prev.
- next  in  P_PARAM_N*P_PARAM_M  Evolution result.
- finish_evo  in  1  Evolution completion flag.
- gen_count  out  16  generations committed since last load.
- still_life  out  1  last committed generation equalled its predecessor.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, prev=0, gen_count=0, still_life=0, load_ready=0, busy=0, load index=0, counters=0. Takes effect mid-LOAD, EVO or HOLD; any partial load is discarded.
- States: IDLE, LOAD, EVO, HOLD.
- IDLE priority, evaluated each cycle: load_start > step > run.
  - load_start: prev<=0, gen_count<=0, still_life<=0, idx<=0, go to LOAD.
  - step=1 or run=1: go to EVO.
  - Otherwise hold.
- LOAD:
  - load_ready=1.
  - On load_valid&&load_ready: prev[idx]<=load_bit, idx++.
  - The beat with idx==N*M-1 returns to IDLE on the next cycle.
  - load_start, step and run are ignored in LOAD.
  - load_valid outside LOAD is ignored.
- EVO (2-cycle minimum, because Evolution registers next one clock after prev settles):
  - Cycle 0: wait.
  - Cycle >=1 with finish_evo==1: commit.
    - prev<=next.
    - still_life<=(next==prev).
    - gen_count<=gen_count+1, wrapping 0xFFFF->0.
  - After commit, go to HOLD if run==1, else IDLE.
  - If finish_evo==0, stay in EVO with no timeout.
  - load_start, step and run are ignored until the commit.
- HOLD:
  - Down-counter loaded with P_TICK_DIV-1 on entry.
  - run==0 at any cycle: go to IDLE next cycle.
  - load_start: behaves as in IDLE (go to LOAD), with priority over the counter.
  - Counter==0 with run==1: go to EVO.
  - Run-mode period: 2+P_TICK_DIV cycles per generation.
- step pulses arriving outside IDLE are dropped, not queued.
- prev changes only on a load beat, on load_start clear, or on commit. It is stable throughout EVO.
- Edges are not wrapped; the boundary rule belongs to Evolution.

Decomposition:
- Package life_pkg:
  - typedef enum life_state_t {IDLE, LOAD, EVO, HOLD}.
  - localparam LIFE_CELLS = P_PARAM_N*P_PARAM_M.
  - localparam GEN_W = 16.
- Sub-module life_tick_counter: parameterised down-counter with load/enable/zero. Used for HOLD pacing and the EVO wait.

Test Plan:
1. Reset mid-LOAD after 7 beats -> prev=0, busy=0, load_ready=0, gen_count=0 within the same cycle rst_n falls.
2. Load 5x5 horizontal blinker (bits 11,12,13 =1, 25 beats, load_valid gaps inserted), then step -> prev has bits 7,12,17 set, gen_count=1, still_life=0, busy high exactly 2 cycles.
3. Load 2x2 block (bits 0,1,5,6), then step -> prev unchanged, still_life=1, gen_count=1.
4. Blinker with run=1 held for 30 cycles, P_TICK_DIV=4 -> commits spaced 6 cycles apart, prev alternates between horizontal and vertical, gen_count=5; drop run during HOLD -> IDLE next cycle, no further commit.
5. step pulsed during EVO and load_start pulsed during LOAD -> both ignored, gen_count advances by exactly 1.
6. Force gen_count to 0xFFFF, then step -> gen_count=0x0000.
